pifo_ingress_arb: RTL and testbench

PIFO_INGRESS_ARB -- requirements
Module: pifo_ingress_arb

---
 rtl/pifo_pkg.sv | 43 ++++
 rtl/rr_arb.sv | 57 +++++
 rtl/pifo_ingress_arb.sv | 124 ++++++++++++
 tb/tb_pifo_ingress_arb.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pifo_pkg
// Purpose  : Shared definitions for the PIFO ingress path: the operation
//            enum, tree-to-port mapping helpers and default widths.
// Revision : 1.0 - initial release
// ============================================================================
package pifo_pkg;

    // Encoding matches the i_req_is_push request bit (1 = push).
    typedef enum logic {
        OP_POP  = 1'b0,
        OP_PUSH = 1'b1
    } op_e;

    localparam int PTW_DEFAULT      = 16;
    localparam int MTW_DEFAULT      = 0;
    localparam int LEVEL_DEFAULT    = 4;
    localparam int TREE_NUM_DEFAULT = 8;
    localparam int TREE_CAP_DEFAULT = 30;

    // Port that serves tree t (LEVEL is a power of two).
    function automatic int tree_port(input int t, input int level);
        return t & (level - 1);
    endfunction

    // Position of tree t among the trees sharing its port.
    function automatic int tree_slot(input int t, input int level);
        return t / level;
    endfunction

    // Width of an index into n entries, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must hold 0..cap inclusive.
    function automatic int occ_width(input int cap);
        return $clog2(cap + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb
// Purpose  : N-way round-robin arbiter with a registered priority pointer.
//            The grant is combinational; after a grant the pointer moves to
//            the requester after the winner, otherwise it holds.
// Ports    : i_clk, i_rst (sync, active-high) - clock / reset
//            i_req [N]   - request vector
//            o_gnt [N]   - one-hot grant
//            o_idx       - index of the granted requester
//            o_any       - a grant was made this cycle
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb
    import pifo_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N-1:0]           i_req,
    output logic [N-1:0]           o_gnt,
    output logic [id_width(N)-1:0] o_idx,
    output logic                   o_any
);

    localparam int c_IW = id_width(N);

    logic [c_IW-1:0] r_ptr;

    // Scan from the pointer position, wrapping; the first requester wins.
    always_comb begin
        int w_j;
        w_j   = 0;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_j = (int'(r_ptr) + i) % N;
            if (!o_any && i_req[w_j]) begin
                o_any      = 1'b1;
                o_idx      = c_IW'(w_j);
                o_gnt[w_j] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (o_any) begin
            r_ptr <= (o_idx == c_IW'(N - 1)) ? '0 : o_idx + c_IW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pifo_ingress_arb.sv
`default_nettype none
// ============================================================================
// Module   : pifo_ingress_arb
// Purpose  : Arbitrates per-tree push/pop requests onto LEVEL PIFO task
//            ports. Tree t is served by port t & (LEVEL-1); each port grants
//            at most one tree per cycle in round-robin order, with zero
//            latency. A full task FIFO blocks its port.
//            Macro PIFO_INGRESS_OCC_CHECK_EN enables per-tree occupancy
//            tracking: pushes stall at TREE_CAP and pops to an empty tree
//            are consumed without issue and flagged on o_pop_drop.
// Ports    : i_clk, i_rst (sync, active-high)
//            i_req_valid/i_req_is_push/i_req_data/o_req_ready - per tree
//            o_push/o_pop/o_tree_id/o_push_data/i_task_fifo_full - per port
//            o_pop_drop - per tree, pop-to-empty consumed pulse
// Revision : 1.0 - initial release
// ============================================================================
module pifo_ingress_arb
    import pifo_pkg::*;
#(
    parameter int PTW      = PTW_DEFAULT,
    parameter int MTW      = MTW_DEFAULT,
    parameter int LEVEL    = LEVEL_DEFAULT,
    parameter int TREE_NUM = TREE_NUM_DEFAULT,
    parameter int TREE_CAP = TREE_CAP_DEFAULT
) (
    input  logic                                     i_clk,
    input  logic                                     i_rst,
    input  logic [TREE_NUM-1:0]                      i_req_valid,
    input  logic [TREE_NUM-1:0]                      i_req_is_push,
    input  logic [TREE_NUM-1:0][MTW+PTW-1:0]         i_req_data,
    output logic [TREE_NUM-1:0]                      o_req_ready,
    output logic [LEVEL-1:0]                         o_push,
    output logic [LEVEL-1:0]                         o_pop,
    output logic [LEVEL-1:0][$clog2(TREE_NUM)-1:0]   o_tree_id,
    output logic [LEVEL-1:0][MTW+PTW-1:0]            o_push_data,
    input  logic [LEVEL-1:0]                         i_task_fifo_full,
    output logic [TREE_NUM-1:0]                      o_pop_drop
);

    localparam int c_SLOTS = TREE_NUM / LEVEL;
    localparam int c_SW    = id_width(c_SLOTS);
    localparam int c_TIDW  = $clog2(TREE_NUM);
    localparam int c_DW    = MTW + PTW;

    // Per-tree capacity status; constant zero when tracking is compiled out.
    logic [TREE_NUM-1:0] w_full;
    logic [TREE_NUM-1:0] w_empty;

`ifdef PIFO_INGRESS_OCC_CHECK_EN
    localparam int              c_OW  = occ_width(TREE_CAP);
    localparam logic [c_OW-1:0] c_CAP = c_OW'(TREE_CAP);
    localparam logic [c_OW-1:0] c_ONE = c_OW'(1);

    logic [TREE_NUM-1:0][c_OW-1:0] r_occ;

    always_comb begin
        for (int t = 0; t < TREE_NUM; t++) begin
            w_full[t]  = (r_occ[t] == c_CAP);
            w_empty[t] = (r_occ[t] == '0);
        end
    end

    // A ready pop on an empty tree is a drop and leaves the count at zero;
    // a ready push is only possible below capacity, so no wrap either way.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_occ <= '0;
        end else begin
            for (int t = 0; t < TREE_NUM; t++) begin
                if (o_req_ready[t]) begin
                    if (i_req_is_push[t]) begin
                        r_occ[t] <= r_occ[t] + c_ONE;
                    end else if (!w_empty[t]) begin
                        r_occ[t] <= r_occ[t] - c_ONE;
                    end
                end
            end
        end
    end
`else
    assign w_full  = '0;
    assign w_empty = '0;
`endif

    for (genvar p = 0; p < LEVEL; p++) begin : g_port
        logic [c_SLOTS-1:0] w_req;
        logic [c_SLOTS-1:0] w_gnt;
        logic [c_SW-1:0]    w_idx;
        logic               w_any;
        logic [c_TIDW-1:0]  w_tid;
        op_e                w_op;

        for (genvar k = 0; k < c_SLOTS; k++) begin : g_slot
            localparam int c_T = p + k * LEVEL;
            // Reset and a full task FIFO remove every request from the
            // arbiter, which forces ready/push/pop/drop low in one place.
            assign w_req[k] = i_req_valid[c_T] & ~i_task_fifo_full[p] & ~i_rst
                            & ~(i_req_is_push[c_T] & w_full[c_T]);
            assign o_req_ready[c_T] = w_gnt[k];
            assign o_pop_drop[c_T]  = w_gnt[k] & ~i_req_is_push[c_T] & w_empty[c_T];
        end

        rr_arb #(
            .N (c_SLOTS)
        ) u_rr_arb (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_req (w_req),
            .o_gnt (w_gnt),
            .o_idx (w_idx),
            .o_any (w_any)
        );

        assign w_tid = c_TIDW'(int'(w_idx) * LEVEL + p);
        assign w_op  = op_e'(i_req_is_push[w_tid]);

        assign o_push[p]      = w_any && (w_op == OP_PUSH);
        assign o_pop[p]       = w_any && (w_op == OP_POP) && !w_empty[w_tid];
        assign o_tree_id[p]   = (o_push[p] || o_pop[p]) ? w_tid : '0;
        assign o_push_data[p] = o_push[p] ? i_req_data[w_tid] : c_DW'(0);
    end

endmodule
`default_nettype wire

// File: tb/tb_pifo_ingress_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_pifo_ingress_arb
// Purpose  : Directed self-checking bench for pifo_ingress_arb with
//            LEVEL=4, TREE_NUM=8, TREE_CAP=30. Behaviour that depends on
//            PIFO_INGRESS_OCC_CHECK_EN is selected with the same macro.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pifo_ingress_arb;

    localparam int PTW      = 16;
    localparam int MTW      = 0;
    localparam int LEVEL    = 4;
    localparam int TREE_NUM = 8;
    localparam int TREE_CAP = 30;

    logic                        clk;
    logic                        rst;
    logic [7:0]                  req_valid;
    logic [7:0]                  req_is_push;
    logic [7:0][15:0]            req_data;
    logic [7:0]                  req_ready;
    logic [3:0]                  push;
    logic [3:0]                  pop;
    logic [3:0][2:0]             tree_id;
    logic [3:0][15:0]            push_data;
    logic [3:0]                  fifo_full;
    logic [7:0]                  pop_drop;

    int n_chk;
    int n_err;
    int cnt;

    pifo_ingress_arb #(
        .PTW      (PTW),
        .MTW      (MTW),
        .LEVEL    (LEVEL),
        .TREE_NUM (TREE_NUM),
        .TREE_CAP (TREE_CAP)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_req_valid      (req_valid),
        .i_req_is_push    (req_is_push),
        .i_req_data       (req_data),
        .o_req_ready      (req_ready),
        .o_push           (push),
        .o_pop            (pop),
        .o_tree_id        (tree_id),
        .o_push_data      (push_data),
        .i_task_fifo_full (fifo_full),
        .o_pop_drop       (pop_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled 2ns later.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        fifo_full = '0;
        next();
        next();
        rst = 1'b0;
    endtask

    initial begin
        n_chk       = 0;
        n_err       = 0;
        cnt         = 0;
        rst         = 1'b1;
        req_valid   = '0;
        req_is_push = '0;
        req_data    = '0;
        fifo_full   = '0;
        #1;

        // Requests presented during reset are never accepted.
        req_valid   = 8'hFF;
        req_is_push = 8'hFF;
        settle();
        chk("rst_ready", 32'(req_ready), 32'h00);
        chk("rst_push",  32'(push),      32'h0);
        chk("rst_pop",   32'(pop),       32'h0);
        chk("rst_drop",  32'(pop_drop),  32'h00);
        next();
        req_valid = '0;
        next();
        rst = 1'b0;

        // Trees 1 and 5 share port 1 and alternate.
        req_valid   = 8'h22;
        req_is_push = 8'h22;
        req_data[1] = 16'hA001;
        req_data[5] = 16'hA005;
        settle();
        chk("rr_c1_ready", 32'(req_ready),    32'h02);
        chk("rr_c1_tid",   32'(tree_id[1]),   32'd1);
        chk("rr_c1_push",  32'(push),         32'h2);
        chk("rr_c1_data",  32'(push_data[1]), 32'hA001);
        next(); settle();
        chk("rr_c2_ready", 32'(req_ready),    32'h20);
        chk("rr_c2_tid",   32'(tree_id[1]),   32'd5);
        chk("rr_c2_data",  32'(push_data[1]), 32'hA005);
        next(); settle();
        chk("rr_c3_ready", 32'(req_ready),    32'h02);
        chk("rr_c3_tid",   32'(tree_id[1]),   32'd1);
        next();
        req_valid = '0;
        settle();
        chk("idle_ready", 32'(req_ready),    32'h00);
        chk("idle_push",  32'(push),         32'h0);
        chk("idle_data",  32'(push_data[1]), 32'h0000);
        next();
        next();
        // Pointer held across idle cycles: tree 5 is next.
        req_valid = 8'h22;
        settle();
        chk("rr_hold_ready", 32'(req_ready),  32'h20);
        chk("rr_hold_tid",   32'(tree_id[1]), 32'd5);
        next(); settle();
        chk("rr_after_ready", 32'(req_ready), 32'h02);
        next();
        req_valid = '0;

        // Port 2 blocked by its task FIFO; port 0 keeps issuing.
        req_valid   = 8'h05;
        req_is_push = 8'h05;
        req_data[2] = 16'hB002;
        req_data[0] = 16'hB000;
        fifo_full   = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("ff_ready", 32'(req_ready), 32'h01);
            chk("ff_push",  32'(push),      32'h1);
            next();
        end
        fifo_full = 4'b0000;
        req_valid = 8'h04;
        settle();
        chk("ff_rel_ready", 32'(req_ready),    32'h04);
        chk("ff_rel_push",  32'(push),         32'h4);
        chk("ff_rel_tid",   32'(tree_id[2]),   32'd2);
        chk("ff_rel_data",  32'(push_data[2]), 32'hB002);
        next();
        req_valid = '0;

        // Pop to tree 3 straight after reset.
        do_reset();
        req_valid   = 8'h08;
        req_is_push = 8'h00;
        settle();
        chk("pop3_ready", 32'(req_ready),  32'h08);
        chk("pop3_data",  32'(push_data[3]), 32'h0000);
`ifdef PIFO_INGRESS_OCC_CHECK_EN
        chk("pop3_drop",  32'(pop_drop),   32'h08);
        chk("pop3_pop",   32'(pop),        32'h0);
`else
        chk("pop3_drop",  32'(pop_drop),   32'h00);
        chk("pop3_pop",   32'(pop),        32'h8);
        chk("pop3_tid",   32'(tree_id[3]), 32'd3);
`endif
        next();
        req_valid = '0;
        settle();
        chk("pop3_drop_end", 32'(pop_drop), 32'h00);

        // Fill tree 0 to capacity, then probe the 31st push.
        do_reset();
        req_valid   = 8'h01;
        req_is_push = 8'h01;
        req_data[0] = 16'hC000;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            settle();
            if (req_ready == 8'h01 && push == 4'h1) cnt++;
            next();
        end
        chk("fill30", 32'(cnt), 32'd30);
        settle();
`ifdef PIFO_INGRESS_OCC_CHECK_EN
        chk("cap_stall_ready", 32'(req_ready), 32'h00);
        chk("cap_stall_push",  32'(push),      32'h0);
        next();
        // Tree 4 shares port 0 and is chosen over the stalled tree 0.
        req_valid   = 8'h11;
        req_is_push = 8'h11;
        settle();
        chk("cap_skip1", 32'(req_ready), 32'h10);
        next(); settle();
        chk("cap_skip2", 32'(req_ready), 32'h10);
        next();
        req_valid = '0;
        next();
        req_valid   = 8'h01;
        req_is_push = 8'h00;
        settle();
        chk("cap_pop_ready", 32'(req_ready), 32'h01);
        chk("cap_pop_pop",   32'(pop),       32'h1);
        chk("cap_pop_drop",  32'(pop_drop),  32'h00);
        next();
        req_is_push = 8'h01;
        settle();
        chk("cap_resume_ready", 32'(req_ready), 32'h01);
        chk("cap_resume_push",  32'(push),      32'h1);
        next(); settle();
        chk("cap_refull_ready", 32'(req_ready), 32'h00);
`else
        chk("nocap_ready", 32'(req_ready), 32'h01);
        chk("nocap_push",  32'(push),      32'h1);
`endif
        next();
        req_valid = '0;

        // Reset in the middle of a push burst to tree 6.
        do_reset();
        req_valid   = 8'h40;
        req_is_push = 8'h40;
        req_data[6] = 16'hD006;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            settle();
            if (req_ready == 8'h40 && push == 4'h4 && tree_id[2] == 3'd6) cnt++;
            next();
        end
        chk("burst5", 32'(cnt), 32'd5);
        rst = 1'b1;
        settle();
        chk("mid_rst_ready", 32'(req_ready), 32'h00);
        chk("mid_rst_push",  32'(push),      32'h0);
        chk("mid_rst_pop",   32'(pop),       32'h0);
        next();
        rst         = 1'b0;
        req_is_push = 8'h00;
        settle();
        chk("post_rst_ready", 32'(req_ready), 32'h40);
`ifdef PIFO_INGRESS_OCC_CHECK_EN
        chk("post_rst_drop", 32'(pop_drop), 32'h40);
        chk("post_rst_pop",  32'(pop),      32'h0);
`else
        chk("post_rst_drop", 32'(pop_drop),   32'h00);
        chk("post_rst_pop",  32'(pop),        32'h4);
        chk("post_rst_tid",  32'(tree_id[2]), 32'd6);
`endif
        next();
        req_valid = '0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
